// File: rtl/program_loader_pkg.sv
// Shared types for the byte-stream instruction loader.
// LOADER_CHECKSUM_EN adds the CHECK state (trailing XOR checksum byte).
package program_loader_pkg;

  localparam int unsigned INSN_WIDTH = 28;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned ASM_WIDTH  = INSN_WIDTH - BYTE_WIDTH;
  localparam int unsigned WCNT_WIDTH = 8;

  // MiniAlu instruction word layout
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] dst;
    logic [7:0] src1;
    logic [7:0] src0;
  } insn_t;

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_DATA   = 3'd1,
    ST_WAIT   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // A word count is legal when nonzero and it fits the instruction RAM
  function automatic logic header_ok(input logic [7:0] n, input int unsigned aw);
    return (n != 8'd0) && (32'(n) <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/program_loader_addr_counter.sv
// Write-address up-counter: loads Initial on Reset, increments on Enable.
module program_loader_addr_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] initial_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_o <= initial_i;
    end else if (enable_i) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader filling the instruction RAM; holds the CPU in reset until done.
// Optional trailing XOR checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            iByte,
  input  logic                  iValid,
  output logic                  oReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [INSN_WIDTH-1:0] oWriteData,
  output logic                  oCpuReset,
  output logic                  oDone,
  output logic                  oError
);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [ASM_WIDTH-1:0]    asm_q, asm_d;
  logic [WCNT_WIDTH-1:0]   words_q, words_d;
  logic                    we_q, we_d;
  insn_t                   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    addr_en_c;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic                    xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              xor_q, xor_d;
`endif

  assign xfer = iValid & ready_q;

  program_loader_addr_counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_cnt (
    .Clock     (Clock),
    .Reset     (Reset),
    .enable_i  (addr_en_c),
    .initial_i ('0),
    .count_o   (addr_cnt)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_HEADER;
      idx_q     <= 2'd0;
      asm_q     <= '0;
      words_q   <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      words_q   <= words_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    words_d   = words_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    waddr_d   = waddr_q;
    addr_en_c = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif

    case (state_q)
      ST_HEADER: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = iByte;
`endif
          if (header_ok(iByte, ADDR_WIDTH)) begin
            words_d = WCNT_WIDTH'(iByte);
            idx_d   = 2'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = xor_q ^ iByte;
`endif
          if (idx_q == 2'd0 && iByte[7:4] != 4'd0) begin
            state_d = ST_ERROR;
          end else if (idx_q == 2'd3) begin
            // Shift register leaves byte0[3:0] in the top nibble after three bytes
            we_d      = 1'b1;
            wdata_d   = insn_t'({asm_q, iByte});
            waddr_d   = addr_cnt;
            addr_en_c = 1'b1;
            words_d   = words_q - WCNT_WIDTH'(1);
            idx_d     = 2'd0;
            if (words_q == WCNT_WIDTH'(1)) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_WAIT;
`endif
            end
          end else begin
            asm_d = {asm_q[ASM_WIDTH-BYTE_WIDTH-1:0], iByte};
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_WAIT: state_d = ST_DONE;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          state_d = ((xor_q ^ iByte) == 8'd0) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    ready_d   = (state_d == ST_HEADER) || (state_d == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
             || (state_d == ST_CHECK)
`endif
             ;
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERROR);
    cpu_rst_d = (state_d != ST_DONE);
  end

  assign oReady        = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = waddr_q;
  assign oWriteData    = wdata_q;
  assign oCpuReset     = cpu_rst_q;
  assign oDone         = done_q;
  assign oError        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus random frames
// checked against a frame-level reference model. Honours LOADER_CHECKSUM_EN.
module tb_program_loader;

  logic        Clock;
  logic        Reset;
  logic [7:0]  iByte;
  logic        iValid;
  logic        oReady;
  logic        oWriteEnable;
  logic [7:0]  oWriteAddress;
  logic [27:0] oWriteData;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  program_loader #(.ADDR_WIDTH(8)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iByte         (iByte),
    .iValid        (iValid),
    .oReady        (oReady),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oCpuReset     (oCpuReset),
    .oDone         (oDone),
    .oError        (oError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          errors = 0;
  int          checks = 0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;
  logic [7:0]  fr[$];
  logic [7:0]  cs;
  logic [7:0]  b0;
  int          n;
  bit          ok;

  // Capture every write strobe as {addr, data}
  always @(negedge Clock) begin
    if (oWriteEnable === 1'b1) got_q.push_back({oWriteAddress, oWriteData});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: list of expected writes plus final done/error outcome
  task automatic model(input logic [7:0] f[$]);
    int nw;
    int idx;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    nw = int'(f[0]);
    if (nw == 0) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < nw; w++) begin
      idx = 1 + 4 * w;
      if (idx + 3 >= f.size()) return;
      if (f[idx][7:4] != 4'd0) begin
        exp_err = 1'b1;
        return;
      end
      exp_q.push_back({8'(w), f[idx][3:0], f[idx+1], f[idx+2], f[idx+3]});
    end
`ifdef LOADER_CHECKSUM_EN
    if (f.size() < 4 * nw + 2) return;
    x = 8'd0;
    for (int i = 0; i < 4 * nw + 2; i++) x = x ^ f[i];
    exp_done = (x == 8'd0);
    exp_err  = (x != 8'd0);
`else
    x = 8'd0;
    exp_done = (x == 8'd0);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b, input int gap, output bit sent);
    iValid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      iByte = 8'($urandom);
      @(negedge Clock);
    end
    sent = oReady;
    if (sent) begin
      iByte  = b;
      iValid = 1'b1;
      @(negedge Clock);
      iValid = 1'b0;
    end
  endtask

  task automatic apply_reset(input int cycles);
    Reset  = 1'b1;
    iValid = 1'b1;
    iByte  = 8'h01;
    for (int i = 0; i < cycles; i++) @(negedge Clock);
    check("rst_ready", 64'(oReady), 64'd0);
    check("rst_we", 64'(oWriteEnable), 64'd0);
    check("rst_addr", 64'(oWriteAddress), 64'd0);
    check("rst_data", 64'(oWriteData), 64'd0);
    check("rst_cpu", 64'(oCpuReset), 64'd1);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_err", 64'(oError), 64'd0);
    Reset  = 1'b0;
    iValid = 1'b0;
    @(negedge Clock);
    check("post_rst_ready", 64'(oReady), 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input int maxgap, input bit do_rst);
    bit s;
    int gap;
    if (do_rst) begin
      apply_reset(2);
      got_q.delete();
    end
    model(f);
    for (int i = 0; i < f.size(); i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
      send_byte(f[i], gap, s);
      if (!s) break;
    end
    for (int i = 0; i < 10; i++) begin
      if (oDone || oError) break;
      @(negedge Clock);
    end
    @(negedge Clock);
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, "_done"}, 64'(oDone), 64'(exp_done));
    check({tag, "_err"}, 64'(oError), 64'(exp_err));
    check({tag, "_cpu"}, 64'(oCpuReset), 64'(!exp_done));
    check({tag, "_ready"}, 64'(oReady), 64'd0);
  endtask

  initial begin
    Reset  = 1'b1;
    iValid = 1'b0;
    iByte  = 8'h00;
    @(negedge Clock);

    // Single word with explicit latency checks
    apply_reset(2);
    got_q.delete();
    send_byte(8'h01, 0, ok);
    send_byte(8'h0A, 0, ok);
    send_byte(8'h01, 0, ok);
    send_byte(8'h02, 0, ok);
    send_byte(8'h03, 0, ok);
    check("sw_we", 64'(oWriteEnable), 64'd1);
    check("sw_addr", 64'(oWriteAddress), 64'd0);
    check("sw_data", 64'(oWriteData), 64'hA010203);
    check("sw_done_early", 64'(oDone), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("sw_ready_chk", 64'(oReady), 64'd1);
    send_byte(8'h0B, 0, ok);
`else
    check("sw_ready_wait", 64'(oReady), 64'd0);
    @(negedge Clock);
`endif
    check("sw_done", 64'(oDone), 64'd1);
    check("sw_cpu", 64'(oCpuReset), 64'd0);
    check("sw_we_off", 64'(oWriteEnable), 64'd0);
    repeat (3) @(negedge Clock);
    check("sw_ready_hold", 64'(oReady), 64'd0);
    check("sw_done_hold", 64'(oDone), 64'd1);
    check("sw_nwrites", 64'(got_q.size()), 64'd1);

    // Illegal opcode nibble
    apply_reset(2);
    got_q.delete();
    send_byte(8'h01, 0, ok);
    send_byte(8'h1A, 0, ok);
    check("ill_err", 64'(oError), 64'd1);
    check("ill_ready", 64'(oReady), 64'd0);
    check("ill_cpu", 64'(oCpuReset), 64'd1);
    check("ill_we", 64'(oWriteEnable), 64'd0);
    repeat (3) @(negedge Clock);
    check("ill_nwrites", 64'(got_q.size()), 64'd0);

    // Empty frame
    apply_reset(2);
    got_q.delete();
    send_byte(8'h00, 0, ok);
    check("empty_err", 64'(oError), 64'd1);
    check("empty_ready", 64'(oReady), 64'd0);
    repeat (2) @(negedge Clock);
    check("empty_nwrites", 64'(got_q.size()), 64'd0);

    // Back-pressure: three words with gaps of 1..5 cycles
    fr = '{8'h03, 8'h01, 8'h11, 8'h22, 8'h33, 8'h0F, 8'hFE, 8'hDC, 8'hBA,
           8'h07, 8'h00, 8'h80, 8'h55};
`ifdef LOADER_CHECKSUM_EN
    cs = 8'd0;
    foreach (fr[i]) cs = cs ^ fr[i];
    fr.push_back(cs);
`endif
    run_frame("bp", fr, 5, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: the write stays, the CPU stays in reset
    fr = '{8'h01, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h0C};
    run_frame("badcs", fr, 0, 1'b1);
`endif

    // Reset in mid-word discards the partial frame
    apply_reset(2);
    got_q.delete();
    send_byte(8'h02, 0, ok);
    send_byte(8'h05, 0, ok);
    send_byte(8'h11, 0, ok);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("mid_ready", 64'(oReady), 64'd1);
    fr = '{8'h01, 8'h0B, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(8'h5F);
`endif
    run_frame("mid", fr, 0, 1'b0);

    // Random frames, occasionally illegal or with a corrupted checksum
    for (int k = 0; k < 25; k++) begin
      fr.delete();
      n = int'($urandom_range(1, 6));
      fr.push_back(8'(n));
      for (int w = 0; w < n; w++) begin
        b0 = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
        fr.push_back(b0);
        for (int j = 0; j < 3; j++) fr.push_back(8'($urandom));
      end
`ifdef LOADER_CHECKSUM_EN
      cs = 8'd0;
      foreach (fr[i]) cs = cs ^ fr[i];
      if ($urandom_range(0, 3) == 0) cs = cs ^ (8'd1 << $urandom_range(0, 7));
      fr.push_back(cs);
`endif
      run_frame($sformatf("rand%0d", k), fr, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
